// File: rtl/alu_clk_gate_ctrl_if.sv
// Request/grant and clock-enable bundle between the ALU clock-gate controller and its requesters.
interface alu_clk_gate_ctrl_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req;
  logic               op_done;
  logic               clk_en;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               gate_busy;

  modport master (
    output req,
    output op_done,
    input  clk_en,
    input  grant,
    input  grant_valid,
    input  gate_busy
  );

  modport slave (
    input  req,
    input  op_done,
    output clk_en,
    output grant,
    output grant_valid,
    output gate_busy
  );
endinterface

// File: rtl/alu_clk_gate_ctrl.sv
// ALU clock-gate controller: wakes the gated ALU clock on demand, grants requesters
// round-robin and gates the clock off after a run of idle cycles.
module alu_clk_gate_ctrl #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_clk_gate_ctrl_if.slave   bus_if
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  state_t             state_q;
  logic               clk_en_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               grant_valid_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]   icnt_q;

  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_next;
  logic [IDX_W-1:0]   cand_idx;
  logic               run_exit;

  // Round-robin pick: scan downward so the candidate closest to rr_ptr_q wins.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    cand_idx = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (bus_if.req[cand_idx]) begin
        arb_hit = 1'b1;
        arb_idx = cand_idx;
      end
    end
  end

  assign arb_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

  // A done pulse and a dropped request in the same cycle are one exit.
  assign run_exit = bus_if.op_done || !bus_if.req[gidx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      clk_en_q      <= 1'b0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      wcnt_q        <= '0;
      icnt_q        <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (|bus_if.req) begin
            state_q  <= ST_WAKE;
            clk_en_q <= 1'b1;
            wcnt_q   <= CNT_W'(WAKE_CYCLES - 1);
          end
        end

        ST_WAKE: begin
          if (wcnt_q == '0) begin
            if (arb_hit) begin
              state_q       <= ST_RUN;
              grant_q       <= NUM_REQ'(1) << arb_idx;
              grant_valid_q <= 1'b1;
              gidx_q        <= arb_idx;
              rr_ptr_q      <= arb_next;
            end else begin
              // Demand vanished during wake-up: fall into the idle countdown.
              state_q <= ST_IDLE;
              icnt_q  <= CNT_W'(IDLE_CYCLES - 1);
            end
          end else begin
            wcnt_q <= wcnt_q - CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (run_exit) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            icnt_q        <= CNT_W'(IDLE_CYCLES - 1);
          end
        end

        ST_IDLE: begin
          if (arb_hit) begin
            state_q       <= ST_RUN;
            grant_q       <= NUM_REQ'(1) << arb_idx;
            grant_valid_q <= 1'b1;
            gidx_q        <= arb_idx;
            rr_ptr_q      <= arb_next;
          end else if (icnt_q == '0) begin
            state_q  <= ST_OFF;
            clk_en_q <= 1'b0;
          end else begin
            icnt_q <= icnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q       <= ST_OFF;
          clk_en_q      <= 1'b0;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.clk_en      = clk_en_q;
  assign bus_if.grant       = grant_q;
  assign bus_if.grant_valid = grant_valid_q;
  assign bus_if.gate_busy   = (state_q != ST_OFF);

endmodule

// File: tb/tb_alu_clk_gate_ctrl.sv
// Randomized and directed bench for alu_clk_gate_ctrl with a per-cycle scoreboard.
module tb_alu_clk_gate_ctrl;

  localparam int NR = 2;
  localparam int WK = 2;
  localparam int ID = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_clk_gate_ctrl_if #(.NUM_REQ(NR)) bus_if ();

  alu_clk_gate_ctrl #(
    .NUM_REQ    (NR),
    .WAKE_CYCLES(WK),
    .IDLE_CYCLES(ID),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus_if)
  );

  typedef struct packed {
    logic          clk_en;
    logic [NR-1:0] grant;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: clock on/off, current owner, remaining wake/idle cycles, next rr start.
  bit m_on;
  int m_owner;
  int m_wake;
  int m_idle;
  int m_ptr;

  function automatic void model_reset();
    m_on    = 1'b0;
    m_owner = -1;
    m_wake  = -1;
    m_idle  = 0;
    m_ptr   = 0;
  endfunction

  function automatic void model_grant(logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (r[i]) begin
        m_owner = i;
        m_ptr   = (i + 1) % NR;
        return;
      end
    end
  endfunction

  function automatic void model_step(logic [NR-1:0] r, logic od);
    if (!m_on) begin
      if (r != 0) begin
        m_on   = 1'b1;
        m_wake = WK - 1;
      end
    end else if (m_wake >= 0) begin
      if (m_wake == 0) begin
        m_wake = -1;
        if (r != 0) model_grant(r);
        else        m_idle = ID - 1;
      end else begin
        m_wake = m_wake - 1;
      end
    end else if (m_owner >= 0) begin
      if (od || !r[m_owner]) begin
        m_owner = -1;
        m_idle  = ID - 1;
      end
    end else begin
      if (r != 0)           model_grant(r);
      else if (m_idle == 0) m_on = 1'b0;
      else                  m_idle = m_idle - 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.clk_en = m_on;
    e.grant  = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    e.busy   = m_on;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [NR-1:0] r, logic od);
    @(negedge clk);
    bus_if.req     = r;
    bus_if.op_done = od;
    model_step(r, od);
    sb.push_back(model_out());
  endtask

  task automatic expect_after(string n, logic ce, logic [NR-1:0] g);
    @(posedge clk);
    #2;
    check({n, "_clk_en"}, 32'(bus_if.clk_en), 32'(ce));
    check({n, "_grant"}, 32'(bus_if.grant), 32'(g));
    check({n, "_busy"}, 32'(bus_if.gate_busy), 32'(ce));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_clk_en", 32'(bus_if.clk_en), 32'(0));
    check("arst_grant", 32'(bus_if.grant), 32'(0));
    check("arst_busy", 32'(bus_if.gate_busy), 32'(0));
    sb.delete();
    model_reset();
    bus_if.req     = '0;
    bus_if.op_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every settled post-edge output is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_clk_en", 32'(bus_if.clk_en), 32'(e.clk_en));
        check("sb_grant", 32'(bus_if.grant), 32'(e.grant));
        check("sb_grant_valid", 32'(bus_if.grant_valid), 32'(|e.grant));
        check("sb_gate_busy", 32'(bus_if.gate_busy), 32'(e.busy));
        check("inv_onehot", 32'($onehot0(bus_if.grant)), 32'(1));
        check("inv_grant_gated", 32'((bus_if.grant != 0) && !bus_if.clk_en), 32'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] r;
    logic          od;

    rst            = 1'b1;
    bus_if.req     = '0;
    bus_if.op_done = 1'b0;
    model_reset();
    #23;
    check("reset_clk_en", 32'(bus_if.clk_en), 32'(0));
    check("reset_grant", 32'(bus_if.grant), 32'(0));
    check("reset_busy", 32'(bus_if.gate_busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Wake latency: clk_en after E0, first grant after E2.
    drive(2'b01, 1'b0); expect_after("t1_e0", 1'b1, 2'b00);
    drive(2'b01, 1'b0); expect_after("t1_e1", 1'b1, 2'b00);
    drive(2'b01, 1'b0); expect_after("t1_e2", 1'b1, 2'b01);

    // Completion then idle countdown to clock-off.
    drive(2'b00, 1'b1); expect_after("t2_exit", 1'b1, 2'b00);
    drive(2'b00, 1'b0); expect_after("t2_i1", 1'b1, 2'b00);
    drive(2'b00, 1'b0); expect_after("t2_i2", 1'b1, 2'b00);
    drive(2'b00, 1'b0); expect_after("t2_i3", 1'b1, 2'b00);
    drive(2'b00, 1'b0); expect_after("t2_off", 1'b0, 2'b00);

    // Alternating grants with a one-cycle gap under continuous demand.
    async_reset();
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b0); expect_after("t3_g0", 1'b1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b1); expect_after($sformatf("t3_gap%0d", i), 1'b1, 2'b00);
      drive(2'b11, 1'b0);
      expect_after($sformatf("t3_g%0d", i + 1), 1'b1, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    drive(2'b00, 1'b1); expect_after("t3_end", 1'b1, 2'b00);

    // Dropped request exits RUN; a new request in IDLE is granted with no wake delay.
    drive(2'b01, 1'b0); expect_after("t4_g", 1'b1, 2'b01);
    drive(2'b00, 1'b0); expect_after("t4_drop", 1'b1, 2'b00);
    drive(2'b10, 1'b0); expect_after("t4_fast", 1'b1, 2'b10);

    // Asynchronous reset mid-RUN, then a fresh wake.
    async_reset();
    drive(2'b10, 1'b0);
    drive(2'b10, 1'b0);
    drive(2'b10, 1'b0); expect_after("t5_first", 1'b1, 2'b10);

    // Stray op_done in IDLE, OFF and WAKE must not disturb the sequence.
    drive(2'b00, 1'b1);
    for (int i = 0; i < ID; i++) drive(2'b00, 1'b1);
    expect_after("t6_off", 1'b0, 2'b00);
    drive(2'b00, 1'b1); expect_after("t6_off_od", 1'b0, 2'b00);
    drive(2'b01, 1'b1); expect_after("t6_wake", 1'b1, 2'b00);
    drive(2'b01, 1'b1); expect_after("t6_wake_od", 1'b1, 2'b00);
    drive(2'b01, 1'b0); expect_after("t6_grant", 1'b1, 2'b01);
    drive(2'b00, 1'b0);

    // Randomized traffic with bursts of silence and occasional resets.
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 500 || i == 1100) async_reset();
      if ((i / 60) % 3 == 2) begin
        r = '0;
      end else if ($urandom_range(0, 2) == 0) begin
        r = NR'($urandom_range(0, (1 << NR) - 1));
      end
      od = ($urandom_range(0, 3) == 0);
      drive(r, od);
    end
    drive('0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
